// File: rtl/conv_pkg.sv
// Shared constants, frame-geometry helpers and FSM encoding for the convolution output writer.
package conv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } wr_state_e;

   localparam int MIN_FIFO_DEPTH = 2;

   // 3x3 window with stride 1 loses one pixel on each border.
   function automatic int out_dim(input int img);
      return img - 2;
   endfunction

   function automatic int frame_pixels(input int img_w, input int img_h);
      return out_dim(img_w) * out_dim(img_h);
   endfunction

   // Bits needed to index v entries, never less than 1.
   function automatic int clog2_min1(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/conv_frame_writer_if.sv
// Result-stream input and frame-buffer write port of the convolution output writer.
// Handshake: in_valid has no backpressure (one pixel per asserted cycle); a memory write
// completes in any cycle where mem_we and mem_ready are both 1, and mem_addr/mem_data
// stay stable while mem_we=1 and mem_ready=0.
interface conv_frame_writer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 16
);
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_data;
   logic                  mem_we;
   logic                  mem_ready;

   modport master (
      output in_data, in_valid, mem_ready,
      input  mem_addr, mem_data, mem_we
   );

   modport slave (
      input  in_data, in_valid, mem_ready,
      output mem_addr, mem_data, mem_we
   );
endinterface

// File: rtl/conv_wr_fifo.sv
// Synchronous write FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module conv_wr_fifo
   import conv_pkg::*;
#(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int PW = clog2_min1(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW:0]      wr_ptr_q, wr_ptr_d;
   logic [PW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push;
   logic             do_pop;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem_q[rd_ptr_q[PW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= din;
   end

endmodule

// File: rtl/conv_frame_writer.sv
// Writes the gapped convolution result stream row-major into the output frame buffer.
// Optional CONV_WR_RELU_EN: clamp negative (MSB set) pixels to zero before queuing.
module conv_frame_writer
   import conv_pkg::*;
#(
   parameter int          DATA_WIDTH = 8,
   parameter int          IMG_WIDTH  = 220,
   parameter int          IMG_HEIGHT = 220,
   parameter int          ADDR_WIDTH = 16,
   parameter int unsigned BASE_ADDR  = 0,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   conv_frame_writer_if.slave  bus,
   output logic                busy,
   output logic                frame_done,
   output logic                overflow,
   output wr_state_e           state_dbg
);
   localparam int OUT_W     = out_dim(IMG_WIDTH);
   localparam int OUT_H     = out_dim(IMG_HEIGHT);
   localparam int FRAME_PIX = frame_pixels(IMG_WIDTH, IMG_HEIGHT);
   localparam int CNT_W     = clog2_min1(FRAME_PIX + 1);
   localparam int COL_W     = clog2_min1(OUT_W);
   localparam int ROW_W     = clog2_min1(OUT_H + 1);
   localparam int FIFO_W    = ADDR_WIDTH + DATA_WIDTH;

   localparam logic [CNT_W-1:0]      FRAME_CNT = CNT_W'(FRAME_PIX);
   localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(OUT_W - 1);
   localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

   wr_state_e             state_q, state_d;
   logic [COL_W-1:0]      col_q, col_d;
   logic [ROW_W-1:0]      row_q, row_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]      accept_cnt_q, accept_cnt_d;
   logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
   logic                  overflow_q, overflow_d;

   logic [DATA_WIDTH-1:0] pix_data;
   logic [FIFO_W-1:0]     fifo_dout;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  want_push;

`ifdef CONV_WR_RELU_EN
   assign pix_data = bus.in_data[DATA_WIDTH-1] ? '0 : bus.in_data;
`else
   assign pix_data = bus.in_data;
`endif

   // mem_we comes only from FIFO state, so there is no combinational path from in_valid.
   assign fifo_pop  = !fifo_empty && bus.mem_ready;
   assign want_push = (state_q == ST_RUN) && bus.in_valid && (accept_cnt_q != FRAME_CNT);
   assign fifo_push = want_push && (!fifo_full || fifo_pop);

   conv_wr_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   ({addr_q, pix_data}),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bus.mem_we = !fifo_empty;
   assign {bus.mem_addr, bus.mem_data} = fifo_empty ? '0 : fifo_dout;
   assign overflow   = overflow_q;
   assign state_dbg  = state_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (wr_cnt_q == FRAME_CNT) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy       = (state_q == ST_RUN);
      frame_done = (state_q == ST_DONE);
   end

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      addr_d       = addr_q;
      accept_cnt_d = accept_cnt_q;
      wr_cnt_d     = wr_cnt_q;
      overflow_d   = overflow_q;
      if (state_q == ST_IDLE && start) begin
         col_d        = '0;
         row_d        = '0;
         addr_d       = BASE;
         accept_cnt_d = '0;
         wr_cnt_d     = '0;
         overflow_d   = 1'b0;
      end else begin
         // addr_q tracks BASE + row*OUT_W + col incrementally; a dropped pixel leaves it alone.
         if (fifo_push) begin
            accept_cnt_d = accept_cnt_q + CNT_W'(1);
            addr_d       = addr_q + ADDR_WIDTH'(1);
            if (col_q == COL_LAST) begin
               col_d = '0;
               row_d = row_q + ROW_W'(1);
            end else begin
               col_d = col_q + COL_W'(1);
            end
         end
         if (want_push && !fifo_push) overflow_d = 1'b1;
         if (fifo_pop) wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q        <= '0;
         row_q        <= '0;
         addr_q       <= BASE;
         accept_cnt_q <= '0;
         wr_cnt_q     <= '0;
         overflow_q   <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         addr_q       <= addr_d;
         accept_cnt_q <= accept_cnt_d;
         wr_cnt_q     <= wr_cnt_d;
         overflow_q   <= overflow_d;
      end
   end

endmodule
